// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel row engine.
// The state enum, kernel weights and gradient width helper live here.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ONE    = 2'd1,
    ST_STREAM = 2'd2
  } sobel_state_t;

  localparam int K_EDGE = 1;
  localparam int K_MID  = 2;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_col_kernel.sv
// 3x3 Sobel kernel on one column window; purely combinational.
// Y kernel is compiled in only when SOBEL_Y_EN is defined.
module sobel_col_kernel
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0]        c0 [3],
  input  logic [PIX_W-1:0]        c1 [3],
  input  logic [PIX_W-1:0]        c2 [3],
  output logic signed [PIX_W+2:0] gx,
  output logic signed [PIX_W+2:0] gy
);

  localparam int GW = grad_w(PIX_W);

  localparam logic signed [GW-1:0] KE = GW'(K_EDGE);
  localparam logic signed [GW-1:0] KM = GW'(K_MID);

  function automatic logic signed [GW-1:0] px(
    input logic [PIX_W-1:0] p
  );
    return $signed({3'b000, p});
  endfunction

  assign gx = KE * (px(c0[2]) - px(c0[0]))
            + KM * (px(c1[2]) - px(c1[0]))
            + KE * (px(c2[2]) - px(c2[0]));

  logic unused_mid;

`ifdef SOBEL_Y_EN
  assign gy = (KE * px(c2[0]) + KM * px(c2[1]) + KE * px(c2[2]))
            - (KE * px(c0[0]) + KM * px(c0[1]) + KE * px(c0[2]));
  assign unused_mid = ^c1[1];
`else
  assign gy = '0;
  assign unused_mid = ^{c0[1], c1[1], c2[1]};
`endif

endmodule

// File: rtl/sobel_row_engine.sv
// Streaming row-parallel Sobel engine with two-row history.
// Define SOBEL_Y_EN to build the vertical gradient path.
module sobel_row_engine
  import sobel_pkg::*;
#(
  parameter int COLS  = 3,
  parameter int PIX_W = 8,
  parameter int ROW_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [PIX_W-1:0]        in_row [COLS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [PIX_W+2:0] out_gx [COLS-2],
  output logic signed [PIX_W+2:0] out_gy [COLS-2],
  output logic [ROW_W-1:0]        out_row
);

  sobel_state_t state;

  logic [PIX_W-1:0]        r0 [COLS];
  logic [PIX_W-1:0]        r1 [COLS];
  logic signed [PIX_W+2:0] k_gx [COLS-2];
  logic signed [PIX_W+2:0] k_gy [COLS-2];
  logic [ROW_W-1:0]        row_cnt;
  logic [ROW_W-1:0]        row_nxt;
  logic                    accept;
  logic                    restart;
  logic                    load;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // A row in EMPTY starts a frame even without in_sof.
  assign restart  = accept && (in_sof || state == ST_EMPTY);
  assign load     = accept && !restart && state == ST_STREAM;
  assign row_nxt  = (row_cnt == '1) ? row_cnt : row_cnt + 1'b1;

  for (genvar j = 0; j < COLS-2; j++) begin : g_col
    logic [PIX_W-1:0] w0 [3];
    logic [PIX_W-1:0] w1 [3];
    logic [PIX_W-1:0] w2 [3];
    for (genvar k = 0; k < 3; k++) begin : g_tap
      assign w0[k] = r0[j+k];
      assign w1[k] = r1[j+k];
      assign w2[k] = in_row[j+k];
    end
    sobel_col_kernel #(
      .PIX_W(PIX_W)
    ) u_kernel (
      .c0(w0),
      .c1(w1),
      .c2(w2),
      .gx(k_gx[j]),
      .gy(k_gy[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      row_cnt <= '0;
    end else if (accept) begin
      unique case (1'b1)
        restart: begin
          state   <= ST_ONE;
          row_cnt <= '0;
        end
        load:    row_cnt <= row_nxt;
        default: state <= ST_STREAM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) begin
        r0[i] <= '0;
        r1[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < COLS; i++) begin
        r0[i] <= restart ? '0 : r1[i];
        r1[i] <= in_row[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      for (int j = 0; j < COLS-2; j++) begin
        out_gx[j] <= '0;
        out_gy[j] <= '0;
      end
    end else if (load) begin
      out_valid <= 1'b1;
      out_row   <= row_nxt;
      for (int j = 0; j < COLS-2; j++) begin
        out_gx[j] <= k_gx[j];
        out_gy[j] <= k_gy[j];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_row_engine.sv
// Randomised and directed bench for sobel_row_engine.
// Reference model convolves a window of frame rows with Sobel kernels.
module tb_sobel_row_engine;

  localparam int COLS  = 5;
  localparam int PIX_W = 8;
  localparam int ROW_W = 10;
  localparam int NO    = COLS - 2;
  localparam int GW    = PIX_W + 3;
  localparam int RMAX  = (1 << ROW_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sof;
  logic [PIX_W-1:0]     in_row [COLS];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [GW-1:0] out_gx [NO];
  logic signed [GW-1:0] out_gy [NO];
  logic [ROW_W-1:0]     out_row;

  int vectors = 0;
  int miscompares = 0;

  // Model: frame rows seen so far and the last two of them.
  int h0 [COLS];
  int h1 [COLS];
  int nrows;
  bit m_valid;
  int m_gx [NO];
  int m_gy [NO];
  int m_row;
  int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  sobel_row_engine #(
    .COLS(COLS),
    .PIX_W(PIX_W),
    .ROW_W(ROW_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sof(in_sof),
    .in_row(in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_gx(out_gx),
    .out_gy(out_gy),
    .out_row(out_row)
  );

  always #5 clk = ~clk;

  task automatic rand_row();
    for (int i = 0; i < COLS; i++) in_row[i] = 8'($urandom);
  endtask

  task automatic cycle();
    bit acc;
    bit prod;
    int win [3][COLS];
    int sx;
    int sy;
    acc = in_valid && (!m_valid || out_ready);
    @(posedge clk);
    prod = 0;
    if (!rst_n) begin
      nrows = 0;
      m_valid = 0;
      m_row = 0;
      for (int j = 0; j < NO; j++) begin
        m_gx[j] = 0;
        m_gy[j] = 0;
      end
    end else begin
      if (acc) begin
        if (in_sof || nrows == 0) begin
          for (int i = 0; i < COLS; i++) h1[i] = int'(in_row[i]);
          nrows = 1;
        end else begin
          if (nrows >= 2) begin
            for (int c = 0; c < COLS; c++) begin
              win[0][c] = h0[c];
              win[1][c] = h1[c];
              win[2][c] = int'(in_row[c]);
            end
            for (int j = 0; j < NO; j++) begin
              sx = 0;
              sy = 0;
              for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                  sx += kx[r][c] * win[r][j+c];
                  sy += ky[r][c] * win[r][j+c];
                end
              m_gx[j] = sx;
`ifdef SOBEL_Y_EN
              m_gy[j] = sy;
`else
              m_gy[j] = 0;
`endif
            end
            m_row = (nrows - 1 > RMAX) ? RMAX : nrows - 1;
            prod = 1;
          end
          for (int i = 0; i < COLS; i++) begin
            h0[i] = h1[i];
            h1[i] = int'(in_row[i]);
          end
          nrows++;
        end
      end
      if (prod) m_valid = 1;
      else if (out_ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_valid = 1;
    in_sof = 1;
    out_ready = 1;
    rand_row();
    cycle();
    cycle();
    rst_n = 1;
    in_valid = 0;
    in_sof = 0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    vectors++;
    if (out_row !== '0) begin
      miscompares++;
      $display("FAIL reset_row: got %0d want 0", out_row);
    end
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gx[j] !== '0 || out_gy[j] !== '0) begin
        miscompares++;
        $display("FAIL reset_grad[%0d]: got %0d/%0d want 0/0",
                 j, out_gx[j], out_gy[j]);
      end
    end
  endtask

  task automatic test_vertical_step();
    int exp_gx [NO] = '{1020, 1020, 0};
    out_ready = 1;
    in_valid = 1;
    in_row = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
    in_sof = 1;
    cycle();
    in_sof = 0;
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vstep_early_valid: got %b want 0", out_valid);
    end
    cycle();
    in_valid = 0;
    vectors++;
    if (out_valid !== 1'b1 || out_row !== 10'd1) begin
      miscompares++;
      $display("FAIL vstep_valid_row: got %b/%0d want 1/1",
               out_valid, out_row);
    end
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gx[j] !== GW'(exp_gx[j]) || out_gy[j] !== '0) begin
        miscompares++;
        $display("FAIL vstep_grad[%0d]: got %0d/%0d want %0d/0",
                 j, out_gx[j], out_gy[j], exp_gx[j]);
      end
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vstep_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reversed_step();
    int exp_gx [NO] = '{-1020, -1020, 0};
    out_ready = 1;
    in_valid = 1;
    in_row = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0};
    in_sof = 1;
    cycle();
    in_sof = 0;
    cycle();
    cycle();
    in_valid = 0;
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gx[j] !== GW'(exp_gx[j])) begin
        miscompares++;
        $display("FAIL rstep_gx[%0d]: got %0d want %0d",
                 j, out_gx[j], exp_gx[j]);
      end
    end
    cycle();
  endtask

  task automatic test_horizontal_edge();
    int exp_gy;
`ifdef SOBEL_Y_EN
    exp_gy = 1020;
`else
    exp_gy = 0;
`endif
    out_ready = 1;
    in_valid = 1;
    in_sof = 1;
    in_row = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    cycle();
    in_sof = 0;
    cycle();
    in_row = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    cycle();
    in_valid = 0;
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gy[j] !== GW'(exp_gy) || out_gx[j] !== '0) begin
        miscompares++;
        $display("FAIL hedge_grad[%0d]: got %0d/%0d want 0/%0d",
                 j, out_gx[j], out_gy[j], exp_gy);
      end
    end
    cycle();
  endtask

  task automatic test_backpressure();
    logic signed [GW-1:0] sgx [NO];
    logic signed [GW-1:0] sgy [NO];
    out_ready = 1;
    in_valid = 1;
    in_sof = 1;
    rand_row();
    cycle();
    in_sof = 0;
    rand_row();
    cycle();
    rand_row();
    cycle();
    sgx = out_gx;
    sgy = out_gy;
    out_ready = 0;
    rand_row();
    repeat (3) begin
      cycle();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== 10'd1) begin
        miscompares++;
        $display("FAIL bp_stall: got rdy=%b vld=%b row=%0d want 0/1/1",
                 in_ready, out_valid, out_row);
      end
      for (int j = 0; j < NO; j++) begin
        vectors++;
        if (out_gx[j] !== sgx[j] || out_gy[j] !== sgy[j]) begin
          miscompares++;
          $display("FAIL bp_hold[%0d]: got %0d/%0d want %0d/%0d",
                   j, out_gx[j], out_gy[j], sgx[j], sgy[j]);
        end
      end
    end
    out_ready = 1;
    cycle();
    in_valid = 0;
    vectors++;
    if (out_valid !== 1'b1 || out_row !== 10'd2) begin
      miscompares++;
      $display("FAIL bp_release: got vld=%b row=%0d want 1/2",
               out_valid, out_row);
    end
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gx[j] !== GW'(m_gx[j]) || out_gy[j] !== GW'(m_gy[j])) begin
        miscompares++;
        $display("FAIL bp_next[%0d]: got %0d/%0d want %0d/%0d",
                 j, out_gx[j], out_gy[j], m_gx[j], m_gy[j]);
      end
    end
    cycle();
  endtask

  task automatic test_sof_restart();
    out_ready = 1;
    in_valid = 1;
    in_sof = 1;
    rand_row();
    cycle();
    in_sof = 0;
    repeat (3) begin
      rand_row();
      cycle();
    end
    vectors++;
    if (out_row !== 10'd2) begin
      miscompares++;
      $display("FAIL sof_pre_row: got %0d want 2", out_row);
    end
    in_sof = 1;
    rand_row();
    cycle();
    in_sof = 0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sof_acc1: got %b want 0", out_valid);
    end
    rand_row();
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sof_acc2: got %b want 0", out_valid);
    end
    rand_row();
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || out_row !== 10'd1) begin
      miscompares++;
      $display("FAIL sof_acc3: got vld=%b row=%0d want 1/1",
               out_valid, out_row);
    end
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gx[j] !== GW'(m_gx[j]) || out_gy[j] !== GW'(m_gy[j])) begin
        miscompares++;
        $display("FAIL sof_grad[%0d]: got %0d/%0d want %0d/%0d",
                 j, out_gx[j], out_gy[j], m_gx[j], m_gy[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    in_valid = 1;
    rst_n = 0;
    rand_row();
    cycle();
    rst_n = 1;
    vectors++;
    if (out_valid !== 1'b0 || out_row !== '0) begin
      miscompares++;
      $display("FAIL rmid_clear: got vld=%b row=%0d want 0/0",
               out_valid, out_row);
    end
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gx[j] !== '0 || out_gy[j] !== '0) begin
        miscompares++;
        $display("FAIL rmid_grad[%0d]: got %0d/%0d want 0/0",
                 j, out_gx[j], out_gy[j]);
      end
    end
    out_ready = 1;
    in_sof = 0;
    for (int n = 0; n < 2; n++) begin
      rand_row();
      cycle();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_row%0d: got %b want 0", n, out_valid);
      end
    end
    rand_row();
    cycle();
    in_valid = 0;
    vectors++;
    if (out_valid !== 1'b1 || out_row !== 10'd1) begin
      miscompares++;
      $display("FAIL rmid_first: got vld=%b row=%0d want 1/1",
               out_valid, out_row);
    end
    for (int j = 0; j < NO; j++) begin
      vectors++;
      if (out_gx[j] !== GW'(m_gx[j]) || out_gy[j] !== GW'(m_gy[j])) begin
        miscompares++;
        $display("FAIL rmid_grad2[%0d]: got %0d/%0d want %0d/%0d",
                 j, out_gx[j], out_gy[j], m_gx[j], m_gy[j]);
      end
    end
    cycle();
  endtask

  task automatic test_random_stream();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sof = ($urandom_range(0, 24) == 0);
      rand_row();
      cycle();
      vectors++;
      if (out_valid !== m_valid || in_ready !== (!m_valid || out_ready)) begin
        miscompares++;
        $display("FAIL rand_hs@%0d: got vld=%b rdy=%b want %b/%b",
                 n, out_valid, in_ready, m_valid, !m_valid || out_ready);
      end
      if (m_valid) begin
        vectors++;
        if (out_row !== ROW_W'(m_row)) begin
          miscompares++;
          $display("FAIL rand_row@%0d: got %0d want %0d", n, out_row, m_row);
        end
        for (int j = 0; j < NO; j++) begin
          vectors++;
          if (out_gx[j] !== GW'(m_gx[j]) || out_gy[j] !== GW'(m_gy[j])) begin
            miscompares++;
            $display("FAIL rand_grad@%0d[%0d]: got %0d/%0d want %0d/%0d",
                     n, j, out_gx[j], out_gy[j], m_gx[j], m_gy[j]);
          end
        end
      end
    end
    rst_n = 1;
    in_valid = 0;
    in_sof = 0;
    out_ready = 1;
    cycle();
  endtask

  task automatic test_row_saturation();
    out_ready = 1;
    in_valid = 1;
    in_sof = 1;
    rand_row();
    cycle();
    in_sof = 0;
    for (int n = 0; n < 1030; n++) begin
      rand_row();
      cycle();
      if (n == 1000) begin
        vectors++;
        if (out_row !== 10'd1000) begin
          miscompares++;
          $display("FAIL sat_mid: got %0d want 1000", out_row);
        end
      end
    end
    in_valid = 0;
    vectors++;
    if (out_row !== 10'd1023 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_end: got vld=%b row=%0d want 1/1023",
               out_valid, out_row);
    end
    cycle();
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0;
    in_sof = 0;
    out_ready = 1;
    for (int i = 0; i < COLS; i++) in_row[i] = '0;
    test_reset();
    test_vertical_step();
    test_reversed_step();
    test_horizontal_edge();
    test_backpressure();
    test_sof_restart();
    test_reset_mid();
    test_random_stream();
    test_row_saturation();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_row_engine.md
# sobel_row_engine

Streaming, parametrised Sobel gradient engine that accepts one full image row per handshake and emits horizontal and vertical gradients for the middle row of a sliding 3-row window. Two-row history is held internally, so the producer streams rows only once, with no external line buffering. It sits between the row-parallel pixel source and downstream thresholding/magnitude logic, and uses valid/ready on both sides.

## Interface
- `COLS`, 3: pixels per row; must be ≥ 3.
- `PIX_W`, 8: unsigned pixel width.
- `ROW_W`, 10: width of the output row index.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: `in_row` holds a valid row.
- `in_ready` output 1: engine can accept a row.
- `in_sof` input 1: qualifies `in_row` as row 0 of a new frame.
- `in_row` input `[PIX_W-1:0]` x `COLS`, unpacked: pixel row, index 0 leftmost.
- `out_valid` output 1: gradient row pending.
- `out_ready` input 1: consumer takes the gradient row.
- `out_gx` output signed `[PIX_W+2:0]` x `(COLS-2)`: horizontal gradient. Element j is centred on input column j+1.
- `out_gy` output signed `[PIX_W+2:0]` x `(COLS-2)`: vertical gradient.
- `out_row` output `[ROW_W-1:0]`: frame row index of the window's centre row.

## Operation
- Row accept happens on `in_valid && in_ready`. Define `in_ready = !out_valid || out_ready` (combinational).
- History registers: r0 holds the oldest row, r1 the previous row. The accepted row is r2. On every accept: r0 ← r1, r1 ← r2.
- FSM states:
  - EMPTY: accept moves to ONE.
  - ONE: accept moves to STREAM.
  - STREAM: every accept loads an output.
  - An accept with `in_sof`=1 in any state discards history, stores the row as r1, resets the row counter, and moves to ONE.
  - An accept in EMPTY without `in_sof` is treated as an implicit frame start.
- `out_gx[j]` = (r0[j+2]−r0[j]) + 2·(r1[j+2]−r1[j]) + (r2[j+2]−r2[j]).
- `out_gy[j]` = (r2[j]+2·r2[j+1]+r2[j+2]) − (r0[j]+2·r0[j+1]+r0[j+2]).
- Arithmetic is signed at width PIX_W+3. The range is ±4·(2^PIX_W−1), so it never overflows and there is no saturation.
- `out_row` is 1 for the first output of a frame and increments per output. It saturates at 2^ROW_W−1.
- Edge columns 0 and COLS−1 produce no output (valid-region convolution).

## Timing
- Reset values: `out_valid`=0, `out_gx`/`out_gy` all 0, `out_row`=0, FSM=EMPTY, history registers 0. `in_ready` is 1 immediately after reset.
- Rows presented while `rst_n`=0 are ignored.
- Latency: an accept in STREAM at edge N gives `out_valid`=1 and new data after edge N.
- Outputs are registered and held stable while `out_valid && !out_ready`. While stalled, `in_ready`=0.
- Simultaneous output take and input accept in STREAM: the new result loads and `out_valid` stays 1. There is no bubble, so throughput is 1 row/cycle.
- Output take with no accept: `out_valid` falls next edge.
- `in_sof` mid-frame: a pending output is unaffected and is still delivered. The next two accepts (sof row plus one) produce no output.
- Reset mid-operation: a pending output is dropped and history is cleared. A frame must restart; two rows are needed before the next output.

## Configuration
- `SOBEL_Y_EN` defined: Y kernel logic is compiled in and `out_gy` is as specified.
- `SOBEL_Y_EN` undefined: no Y adders are synthesised, `out_gy` is tied to 0, and port list and timing are unchanged.

## Structure
- Package `sobel_pkg` contains:
  - the FSM state enum (EMPTY/ONE/STREAM);
  - the kernel coefficient localparams;
  - a function returning gradient width from PIX_W.
- Sub-module `sobel_col_kernel` takes three 3-pixel column slices (r0, r1, r2) and returns gx/gy combinationally. It is generated COLS−2 times.
- The top level holds the FSM, history registers, output register, row counter and handshake.

## Test plan
All scenarios use COLS=5 and PIX_W=8.
- Vertical step: three rows {0,0,255,255,255} with `in_sof` on the first → one cycle after the third accept, `out_gx`={1020,1020,0}, `out_gy`={0,0,0}, `out_row`=1.
- Reversed step: three rows {255,255,0,0,0} → `out_gx`={−1020,−1020,0}.
- Horizontal edge: rows all-0, all-0, all-255 → `out_gy`={1020,1020,1020} with `SOBEL_Y_EN`, {0,0,0} without it; `out_gx`=0 in both cases.
- Backpressure: hold `out_ready`=0 for 3 cycles with an output pending → `in_ready`=0 and outputs stable. Then set `out_ready`=1 with `in_valid`=1 → output is taken and the next result loads with no bubble; `out_row` goes from 1 to 2.
- `in_sof` after 4 rows → the next 2 accepts give no `out_valid`; the third gives `out_row`=1.
- Reset: pulse `rst_n` low for 1 cycle while `out_valid`=1 → `out_valid`=0 and outputs 0 next edge. The first 2 rows afterwards produce no output.
